// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// and the select codes that the ALU control decoder and datapath muxes consume.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_AND   = 2'b11;

    localparam logic [1:0] SRC_B_RT       = 2'b00;
    localparam logic [1:0] SRC_B_FOUR     = 2'b01;
    localparam logic [1:0] SRC_B_IMM      = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SHL2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/main_control_fsm.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/write-back
// and decodes every datapath select and enable from the current state.
module main_control_fsm
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    // Held as raw bits so the unused encodings 12-15 remain representable.
    logic [3:0] state_q;
    logic [3:0] next_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= next_state;
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (state_q)
            S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:       next_state = S_MEMADR;
                    OP_RTYPE:           next_state = S_EXEC;
                    OP_BEQ:             next_state = S_BEQ;
                    OP_J:               next_state = S_JUMP;
                    OP_ADDI, OP_ANDI:   next_state = S_IEXEC;
                    default:            next_state = S_FETCH;
                endcase
            end
            S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  next_state = S_FETCH;
            S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   next_state = S_ALUWB;
            S_ALUWB:  next_state = S_FETCH;
            S_BEQ:    next_state = S_FETCH;
            S_IEXEC:  next_state = S_IWB;
            S_IWB:    next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            default:  next_state = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_RT;
        alu_op        = ALU_OP_ADD;
        pc_source     = PC_SRC_ALU;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (state_q)
            S_FETCH: begin
                // IR and PC load only in the cycle memory delivers the word.
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRC_B_IMM_SHL2;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
                    OP_J, OP_ADDI, OP_ANDI: illegal_op = 1'b0;
                    default:                illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_OP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALUOUT;
                instr_done    = 1'b1;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                alu_op    = (opcode == OP_ANDI) ? ALU_OP_AND : ALU_OP_ADD;
            end
            S_IWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PC_SRC_JUMP;
                instr_done = 1'b1;
            end
            default: begin
                alu_src_b = SRC_B_RT;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed, table-driven bench for main_control_fsm: each row drives one cycle
// of inputs and compares the state and the full output bundle against hand values.
module tb_main_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    main_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
        .state(state)
    );

    // Bundle order: pw pwc iord mr mw irw | m2r rdst rw asa | asb | aop | psrc | done ill
    logic [17:0] outs;
    assign outs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a,
                   alu_src_b, alu_op, pc_source, instr_done, illegal_op};

    localparam logic [17:0] O_FETCH_WAIT = 18'b000100_0000_01_00_00_00;
    localparam logic [17:0] O_FETCH_RDY  = 18'b100101_0000_01_00_00_00;
    localparam logic [17:0] O_DECODE     = 18'b000000_0000_11_00_00_00;
    localparam logic [17:0] O_DECODE_ILL = 18'b000000_0000_11_00_00_01;
    localparam logic [17:0] O_MEMADR     = 18'b000000_0001_10_00_00_00;
    localparam logic [17:0] O_MEMRD      = 18'b001100_0000_00_00_00_00;
    localparam logic [17:0] O_MEMWB      = 18'b000000_1010_00_00_00_10;
    localparam logic [17:0] O_MEMWR_WAIT = 18'b001010_0000_00_00_00_00;
    localparam logic [17:0] O_MEMWR_DONE = 18'b001010_0000_00_00_00_10;
    localparam logic [17:0] O_EXEC       = 18'b000000_0001_00_10_00_00;
    localparam logic [17:0] O_ALUWB      = 18'b000000_0110_00_00_00_10;
    localparam logic [17:0] O_BEQ        = 18'b010000_0001_00_01_01_10;
    localparam logic [17:0] O_IEXEC_ADD  = 18'b000000_0001_10_00_00_00;
    localparam logic [17:0] O_IEXEC_AND  = 18'b000000_0001_10_11_00_00;
    localparam logic [17:0] O_IWB        = 18'b000000_0010_00_00_00_10;
    localparam logic [17:0] O_JUMP       = 18'b100000_0000_00_00_10_10;

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, AD = 6'b001000;
    localparam logic [5:0] AN = 6'b001100, IL = 6'b111111;

    typedef struct {
        logic        rst_n;
        logic [5:0]  opcode;
        logic        mem_ready;
        logic [3:0]  exp_state;
        logic [17:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    // Drive inputs on the falling edge so they are settled before the next rising edge.
    task automatic applyStimulus(input logic r, input logic [5:0] op, input logic mr);
        @(negedge clk);
        rst_n     = r;
        opcode    = op;
        mem_ready = mr;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] exp_state,
                               input logic [17:0] exp_out);
        #1;
        tests_run++;
        if (state !== exp_state) begin
            tests_failed++;
            $display("[TB] FAIL %s state: got %0d, expected %0d", name, state, exp_state);
        end
        tests_run++;
        if (outs !== exp_out) begin
            tests_failed++;
            $display("[TB] FAIL %s outputs: got %b, expected %b", name, outs, exp_out);
        end
    endtask

    task automatic addVec(input logic r, input logic [5:0] op, input logic mr,
                          input logic [3:0] st, input logic [17:0] o);
        vecs.push_back('{r, op, mr, st, o});
    endtask

    initial begin
        // Reset held for two edges with memory idle.
        rst_n = 1'b0; opcode = RT; mem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        checkOutput("reset", 4'd0, O_FETCH_WAIT);

        // lw, memory always ready: 0,1,2,3,4
        addVec(1, LW, 0, 0,  O_FETCH_WAIT);
        addVec(1, LW, 1, 0,  O_FETCH_RDY);
        addVec(1, LW, 1, 1,  O_DECODE);
        addVec(1, LW, 1, 2,  O_MEMADR);
        addVec(1, LW, 1, 3,  O_MEMRD);
        addVec(1, LW, 1, 4,  O_MEMWB);
        // sw with three wait cycles in MEMWR
        addVec(1, SW, 1, 0,  O_FETCH_RDY);
        addVec(1, SW, 1, 1,  O_DECODE);
        addVec(1, SW, 1, 2,  O_MEMADR);
        addVec(1, SW, 0, 5,  O_MEMWR_WAIT);
        addVec(1, SW, 0, 5,  O_MEMWR_WAIT);
        addVec(1, SW, 0, 5,  O_MEMWR_WAIT);
        addVec(1, SW, 1, 5,  O_MEMWR_DONE);
        // R-type
        addVec(1, RT, 1, 0,  O_FETCH_RDY);
        addVec(1, RT, 1, 1,  O_DECODE);
        addVec(1, RT, 1, 6,  O_EXEC);
        addVec(1, RT, 1, 7,  O_ALUWB);
        // andi
        addVec(1, AN, 1, 0,  O_FETCH_RDY);
        addVec(1, AN, 1, 1,  O_DECODE);
        addVec(1, AN, 1, 9,  O_IEXEC_AND);
        addVec(1, AN, 1, 10, O_IWB);
        // addi
        addVec(1, AD, 1, 0,  O_FETCH_RDY);
        addVec(1, AD, 1, 1,  O_DECODE);
        addVec(1, AD, 1, 9,  O_IEXEC_ADD);
        addVec(1, AD, 1, 10, O_IWB);
        // beq
        addVec(1, BQ, 1, 0,  O_FETCH_RDY);
        addVec(1, BQ, 1, 1,  O_DECODE);
        addVec(1, BQ, 1, 8,  O_BEQ);
        // j
        addVec(1, JJ, 1, 0,  O_FETCH_RDY);
        addVec(1, JJ, 1, 1,  O_DECODE);
        addVec(1, JJ, 1, 11, O_JUMP);
        // illegal opcode goes straight back to FETCH
        addVec(1, IL, 1, 0,  O_FETCH_RDY);
        addVec(1, IL, 1, 1,  O_DECODE_ILL);
        addVec(1, IL, 0, 0,  O_FETCH_WAIT);
        // j with mem_ready low where it must be ignored
        addVec(1, JJ, 1, 0,  O_FETCH_RDY);
        addVec(1, JJ, 0, 1,  O_DECODE);
        addVec(1, JJ, 0, 11, O_JUMP);
        // lw with a fetch wait and a read wait
        addVec(1, LW, 0, 0,  O_FETCH_WAIT);
        addVec(1, LW, 1, 0,  O_FETCH_RDY);
        addVec(1, LW, 1, 1,  O_DECODE);
        addVec(1, LW, 0, 2,  O_MEMADR);
        addVec(1, LW, 0, 3,  O_MEMRD);
        addVec(1, LW, 1, 3,  O_MEMRD);
        addVec(1, LW, 0, 4,  O_MEMWB);
        addVec(1, LW, 0, 0,  O_FETCH_WAIT);

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("row%0d", i);
            applyStimulus(vecs[i].rst_n, vecs[i].opcode, vecs[i].mem_ready);
            checkOutput(nm, vecs[i].exp_state, vecs[i].exp_out);
        end

        // Reset during a MEMRD wait abandons the load without a done pulse.
        applyStimulus(1, LW, 1); checkOutput("rstrd_fetch",  4'd0, O_FETCH_RDY);
        applyStimulus(1, LW, 1); checkOutput("rstrd_decode", 4'd1, O_DECODE);
        applyStimulus(1, LW, 1); checkOutput("rstrd_memadr", 4'd2, O_MEMADR);
        applyStimulus(1, LW, 0); checkOutput("rstrd_memrd",  4'd3, O_MEMRD);
        applyStimulus(0, LW, 1); checkOutput("rstrd_assert", 4'd3, O_MEMRD);
        applyStimulus(1, LW, 0); checkOutput("rstrd_after",  4'd0, O_FETCH_WAIT);

        // Reset during a MEMWR wait abandons the store.
        applyStimulus(1, SW, 1); checkOutput("rstwr_fetch",  4'd0, O_FETCH_RDY);
        applyStimulus(1, SW, 1); checkOutput("rstwr_decode", 4'd1, O_DECODE);
        applyStimulus(1, SW, 1); checkOutput("rstwr_memadr", 4'd2, O_MEMADR);
        applyStimulus(1, SW, 0); checkOutput("rstwr_memwr",  4'd5, O_MEMWR_WAIT);
        applyStimulus(0, SW, 0); checkOutput("rstwr_assert", 4'd5, O_MEMWR_WAIT);
        applyStimulus(1, SW, 0); checkOutput("rstwr_after",  4'd0, O_FETCH_WAIT);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multicycle main control unit for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states. It drives every datapath mux select and write enable, and produces the 2-bit `alu_op` code consumed by the ALU control decoder, which sits directly downstream. A `mem_ready` handshake lets memory accesses take a variable number of cycles.

## Interface
- No parameters; encodings are fixed in the shared package.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `opcode`  in  6  instruction bits [31:26] from the instruction register; stable from DECODE until the return to FETCH.
- `mem_ready`  in  1  memory has completed the current read/write this cycle.
- `pc_write`, `pc_write_cond`  out  1  unconditional / branch-conditional PC load.
- `iord`  out  1  memory address source: 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`  out  1  memory strobes; held until `mem_ready`.
- `ir_write`  out  1  instruction register load.
- `mem_to_reg`  out  1  write-back data: 0 = ALUOut, 1 = MDR.
- `reg_dst`  out  1  destination register: 0 = rt, 1 = rd.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  1  ALU A input: 0 = PC, 1 = rs.
- `alu_src_b`  out  2  ALU B input: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = immediate<<2.
- `alu_op`  out  2  00 = add, 01 = subtract (beq), 10 = R-type funct decode, 11 = and (andi).
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done`  out  1  one-cycle pulse in the final state of every instruction.
- `illegal_op`  out  1  one-cycle pulse in DECODE when `opcode` is not supported.
- `state`  out  4  current state, for debug.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100.
- The state register resets to FETCH. Outputs decode from the state register, plus `mem_ready` where noted. Any output not listed for a state is 0. `alu_op`, `alu_src_b` and `pc_source` default to 00.
- Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BEQ 8, IEXEC 9, IWB 10, JUMP 11. Encodings 12–15 go to FETCH on the next edge, with all outputs 0.
- FETCH
  - Outputs: `mem_read`=1, `alu_src_b`=01, `ir_write`=`mem_ready`, `pc_write`=`mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when it is 1.
- DECODE
  - Outputs: `alu_src_b`=11.
  - Next state: lw/sw → MEMADR; R-type → EXEC; beq → BEQ; j → JUMP; addi/andi → IEXEC.
  - Any other opcode: FETCH, with `illegal_op`=1.
- MEMADR
  - Outputs: `alu_src_a`=1, `alu_src_b`=10.
  - Next state: lw → MEMRD, sw → MEMWR.
- MEMRD
  - Outputs: `mem_read`=1, `iord`=1.
  - Waits for `mem_ready`, then goes to MEMWB.
- MEMWB
  - Outputs: `reg_write`=1, `mem_to_reg`=1, `instr_done`=1.
  - Next state: FETCH.
- MEMWR
  - Outputs: `mem_write`=1, `iord`=1, `instr_done`=`mem_ready`.
  - Waits for `mem_ready`, then goes to FETCH.
- EXEC
  - Outputs: `alu_src_a`=1, `alu_op`=10.
  - Next state: ALUWB.
- ALUWB
  - Outputs: `reg_write`=1, `reg_dst`=1, `instr_done`=1.
  - Next state: FETCH.
- BEQ
  - Outputs: `alu_src_a`=1, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01, `instr_done`=1.
  - Next state: FETCH.
- IEXEC
  - Outputs: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00 for addi or 11 for andi.
  - Next state: IWB.
- IWB
  - Outputs: `reg_write`=1, `instr_done`=1.
  - Next state: FETCH.
- JUMP
  - Outputs: `pc_write`=1, `pc_source`=10, `instr_done`=1.
  - Next state: FETCH.

## Timing
- Reset: the edge with `rst_n`=0 loads FETCH. Outputs then show FETCH values; with `mem_ready`=0 all write enables are 0.
- Reset mid-instruction, including during a memory wait, abandons the instruction. No `instr_done` pulse is produced.
- Cycle counts with `mem_ready` held high:
  - lw: 5 cycles.
  - sw, R-type, addi, andi: 4 cycles.
  - beq, j: 3 cycles.
- Each cycle with `mem_ready` low in FETCH, MEMRD or MEMWR adds one cycle.
- Memory strobes stay constant through a wait.
- `ir_write` and `pc_write` in FETCH assert only in the `mem_ready` cycle, and exactly once per fetch.
- `mem_ready` outside FETCH, MEMRD and MEMWR is ignored.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - state encodings;
  - opcode constants;
  - the `alu_op` codes shared with the ALU control decoder;
  - `alu_src_b` and `pc_source` select codes.
- Single module. No sub-module: a next-state block and an output-decode block inside it.

## Test plan
- Reset with `rst_n`=0 for 2 cycles, `mem_ready`=0 → `state`=0 and all write enables 0; then `mem_ready`=1 → one `ir_write` and one `pc_write` pulse, then `state`=1.
- lw (100011), `mem_ready`=1 → states 0,1,2,3,4,0; `iord`=1 in state 3; `reg_write`=1 with `mem_to_reg`=1 in state 4; `instr_done` pulses once.
- sw (101011) with `mem_ready` low for 3 cycles in MEMWR → `mem_write` held 4 cycles; `reg_write` never asserts; back to FETCH.
- R-type then andi (001100) → `alu_op`=10 in EXEC and 11 in IEXEC; `reg_dst`=1 in ALUWB and 0 in IWB.
- beq (000100) and j (000010) → `pc_write_cond`=1 with `pc_source`=01; `pc_write`=1 with `pc_source`=10; each takes 3 cycles.
- Illegal opcode 111111 → `illegal_op` pulse in DECODE, then FETCH.
- Reset asserted in MEMRD → FETCH next cycle, no `instr_done` pulse.
